dmem_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer in front of the single-port data memory.
- Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader.
- Grants one access at a time, round-robin, and drives the memory's command signals from registered state.
- Collects the memory's one-cycle-late read data, checks size and alignment, and returns a response to the winning requester.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Purpose: round-robin arbiter and access sequencer for two requesters sharing one single-port data memory.
// Latency: legal access 3 cycles from ready back to IDLE (accept, ACCESS, RESP); illegal access 2 cycles.
// Backpressure: ready[i] is raised only in IDLE for the winner; everyone else holds req/p_* until accepted.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req/ready             - per-requester command handshake (ready is combinational, IDLE only)
//   p_write/p_unsigned/p_size/p_addr/p_wdata - per-requester command fields
//   resp_valid/resp_err/resp_rdata           - one-cycle response to the owning requester
//   mem_write/mem_read/is_unsigned/xfer_size/address/w_data/r_data - memory side;
//                           r_data is valid the cycle after the address is presented
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic [1:0]       ready,
  input  logic [1:0]       p_write,
  input  logic [1:0]       p_unsigned,
  input  logic [1:0][2:0]  p_size,
  input  logic [1:0][31:0] p_addr,
  input  logic [1:0][31:0] p_wdata,
  output logic [1:0]       resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic             mem_write,
  output logic             mem_read,
  output logic             is_unsigned,
  output logic [2:0]       xfer_size,
  output logic [31:0]      address,
  output logic [31:0]      w_data,
  input  logic [31:0]      r_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic        write_q;
  logic        unsigned_q;
  logic        err_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        winner;
  logic        grant;
  logic        cmd_err;
  logic [2:0]  sel_size;
  logic [31:0] sel_addr;
  logic [32:0] end_addr;

  // Winner selection: a lone requester wins outright; on a tie the port
  // that did not win last time goes first.
  always_comb begin
    winner = req[1];
    if (&req) winner = ~last_grant_q;
  end

  assign grant    = (state_q == IDLE) && (|req);
  assign sel_size = p_size[winner];
  assign sel_addr = p_addr[winner];
  // 33-bit sum so an address near 2^32 cannot wrap back into range.
  assign end_addr = {1'b0, sel_addr} + {30'b0, sel_size};

  always_comb begin
    cmd_err = 1'b0;
    case (sel_size)
      3'd1:    cmd_err = 1'b0;
      3'd2:    cmd_err = sel_addr[0];
      3'd4:    cmd_err = |sel_addr[1:0];
      default: cmd_err = 1'b1;
    endcase
    if (end_addr > 33'(MEM_BYTES)) cmd_err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ready   = 2'b00;
    case (state_q)
      IDLE: begin
        if (grant) begin
          ready   = winner ? 2'b10 : 2'b01;
          // Illegal commands skip the memory cycle entirely.
          state_d = cmd_err ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      err_q        <= 1'b0;
      size_q       <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        last_grant_q <= winner;
        owner_q      <= winner;
        write_q      <= p_write[winner];
        unsigned_q   <= p_unsigned[winner];
        err_q        <= cmd_err;
        size_q       <= sel_size;
        addr_q       <= sel_addr;
        wdata_q      <= p_wdata[winner];
      end
    end
  end

  // Command fields sit on the memory bus permanently; only the strobes
  // qualify them, and only during ACCESS.
  assign address     = addr_q;
  assign w_data      = wdata_q;
  assign xfer_size   = size_q;
  assign is_unsigned = unsigned_q;
  assign mem_write   = (state_q == ACCESS) &&  write_q;
  assign mem_read    = (state_q == ACCESS) && !write_q;

  // Memory read data arrives one cycle after ACCESS, i.e. during RESP,
  // and is forwarded without another register stage.
  assign resp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = ((state_q == RESP) && !write_q && !err_q) ? r_data : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [1:0]       ready;
  logic [1:0]       p_write, p_unsigned;
  logic [1:0][2:0]  p_size;
  logic [1:0][31:0] p_addr, p_wdata;
  logic [1:0]       resp_valid;
  logic             resp_err;
  logic [31:0]      resp_rdata;
  logic             mem_write, mem_read, is_unsigned;
  logic [2:0]       xfer_size;
  logic [31:0]      address, w_data;
  logic [31:0]      r_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .req(req), .ready(ready),
    .p_write(p_write), .p_unsigned(p_unsigned), .p_size(p_size),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_write(mem_write), .mem_read(mem_read), .is_unsigned(is_unsigned),
    .xfer_size(xfer_size), .address(address), .w_data(w_data), .r_data(r_data)
  );

  // ---------------- memory device (no reset, registered read) ----------------
  logic [7:0] dev_mem [0:MEM_BYTES-1];

  function automatic logic [31:0] dev_read(logic [31:0] ad, logic [2:0] sz, logic u);
    logic [31:0] v = '0;
    for (int k = 0; k < 4; k++)
      if (k < int'(sz)) v[8*k +: 8] = dev_mem[(int'(ad[5:0]) + k) % MEM_BYTES];
    if (!u) begin
      if (sz == 3'd1) v = {{24{v[7]}}, v[7:0]};
      if (sz == 3'd2) v = {{16{v[15]}}, v[15:0]};
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_write)
      for (int k = 0; k < 4; k++)
        if (k < int'(xfer_size)) dev_mem[(int'(address[5:0]) + k) % MEM_BYTES] <= w_data[8*k +: 8];
    if (mem_read) r_data <= dev_read(address, xfer_size, is_unsigned);
  end

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic        w;
    logic        u;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  cmd_t        q0[$], q1[$];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  int          cyc, free_at, acc_cyc, resp_cyc;
  int          out_resp [2];
  logic        resp_port, resp_e, last_grant;
  logic [31:0] resp_d;
  cmd_t        cur;

  int          n_vec = 0, n_err = 0;
  int          gport[$], gcyc[$];
  int          last_ready_cyc, last_resp_cyc, nwr, nrd, nready1, nresp1;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(logic w, logic u, int sz, int a, logic [31:0] d);
    cmd_t c;
    c.w = w; c.u = u; c.sz = 3'(sz); c.a = 32'(a); c.d = d;
    return c;
  endfunction

  function automatic bit model_err(cmd_t c);
    int     sz  = int'(c.sz);
    longint a64 = longint'({32'b0, c.a});
    if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b1;
    if (a64 % sz != 0) return 1'b1;
    if (a64 + sz > MEM_BYTES) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(cmd_t c);
    longint v  = 0;
    int     sz = int'(c.sz);
    int     a  = int'(c.a);
    for (int k = 0; k < sz; k++) v += longint'(ref_mem[a + k]) << (8 * k);
    if (!c.u && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
    return v[31:0];
  endfunction

  task automatic model_store(cmd_t c);
    for (int k = 0; k < int'(c.sz); k++)
      ref_mem[int'(c.a) + k] = 8'((c.d >> (8 * k)) & 32'hFF);
  endtask

  function automatic int qsz(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction
  function automatic cmd_t qfront(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction
  task automatic qpush(int i, cmd_t c);
    if (i == 0) q0.push_back(c); else q1.push_back(c);
  endtask
  task automatic qpop(int i);
    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endtask

  task automatic drive();
    cmd_t c;
    for (int i = 0; i < 2; i++) begin
      if (qsz(i) > 0) begin
        c = qfront(i);
        p_write[i] = c.w; p_unsigned[i] = c.u; p_size[i] = c.sz;
        p_addr[i] = c.a;  p_wdata[i] = c.d;
        req[i] = !reset && (out_resp[i] < 0 || cyc >= out_resp[i]);
      end else begin
        req[i] = 1'b0;
        p_write[i] = 1'($urandom); p_unsigned[i] = 1'($urandom);
        p_size[i] = 3'($urandom); p_addr[i] = $urandom; p_wdata[i] = $urandom;
      end
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    logic [1:0] er;
    logic       g, w, e;
    cmd_t       c;
    logic [31:0] d;
    @(negedge clk);
    g = 1'b0; w = 1'b0; er = 2'b00; e = 1'b0; d = '0; c = '0;
    if (cyc >= free_at && req != 2'b00) begin
      w  = (req == 2'b11) ? ~last_grant : req[1];
      er = w ? 2'b10 : 2'b01;
      g  = !reset;
    end
    check("ready", ready, er);
    check("mem_write", mem_write, (cyc == acc_cyc) && cur.w);
    check("mem_read", mem_read, (cyc == acc_cyc) && !cur.w);
    check("address", address, cur.a);
    check("xfer_size", xfer_size, cur.sz);
    check("w_data", w_data, cur.d);
    check("is_unsigned", is_unsigned, cur.u);
    check("resp_valid", resp_valid, (cyc == resp_cyc) ? (resp_port ? 2'b10 : 2'b01) : 2'b00);
    check("resp_err", resp_err, (cyc == resp_cyc) && resp_e);
    check("resp_rdata", resp_rdata, (cyc == resp_cyc) ? resp_d : 32'd0);
    if (ready != 2'b00) begin
      gport.push_back(ready[1] ? 1 : 0); gcyc.push_back(cyc);
      last_ready_cyc = cyc;
      if (ready[1]) nready1++;
    end
    if (resp_valid != 2'b00) begin
      last_resp_cyc = cyc; last_rdata = resp_rdata; last_err = resp_err;
      if (resp_valid[1]) nresp1++;
    end
    if (mem_write) nwr++;
    if (mem_read) nrd++;
    if (g) begin
      c = qfront(int'(w));
      e = model_err(c);
      if (!e && !c.w) d = model_load(c);
      if (!e && c.w) model_store(c);
    end
    @(posedge clk);
    if (reset) begin
      cur = '0; last_grant = 1'b1; free_at = cyc + 1;
      acc_cyc = -1; resp_cyc = -1; out_resp[0] = -1; out_resp[1] = -1;
    end else if (g) begin
      cur = c; last_grant = w; resp_port = w; resp_e = e; resp_d = d;
      acc_cyc  = e ? -1 : cyc + 1;
      resp_cyc = e ? cyc + 1 : cyc + 2;
      free_at  = resp_cyc + 1;
      out_resp[int'(w)] = resp_cyc;
      qpop(int'(w));
    end
    cyc++;
    #1;
    drive();
  endtask

  task automatic run_idle(int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < free_at) && n < max) begin
      step(); n++;
    end
    if (n >= max) check("timeout", 1, 0);
    step();
  endtask

  function automatic cmd_t rand_legal_load(int sz);
    return mk(1'b0, 1'($urandom), sz, $urandom_range(0, MEM_BYTES / sz - 1) * sz, $urandom);
  endfunction

  function automatic cmd_t rand_cmd();
    int r = $urandom_range(0, 9);
    int sz = (r < 3) ? 1 : (r < 6) ? 2 : (r < 9) ? 4 : $urandom_range(0, 7);
    int a  = ($urandom_range(0, 9) == 0) ? $urandom_range(56, 80) : $urandom_range(0, 63);
    if ($urandom_range(0, 1) == 0 && sz > 0) a = a - (a % sz);
    return mk(1'($urandom), 1'($urandom), sz, a, $urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int e_sz [4] = '{2, 4, 3, 4};
    int e_ad [4] = '{3, 6, 0, 64};
    int snap_r, snap_v;
    for (int k = 0; k < MEM_BYTES; k++) begin dev_mem[k] = 8'h00; ref_mem[k] = 8'h00; end
    r_data = '0;
    reset = 1'b1; req = 2'b00;
    p_write = '0; p_unsigned = '0; p_size = '0; p_addr = '0; p_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0; free_at = 0; acc_cyc = -1; resp_cyc = -1; out_resp[0] = -1; out_resp[1] = -1;
    resp_port = 1'b0; resp_e = 1'b0; resp_d = '0; last_grant = 1'b1; cur = '0;
    last_ready_cyc = 0; last_resp_cyc = 0; nwr = 0; nrd = 0; nready1 = 0; nresp1 = 0;
    last_rdata = '0; last_err = 1'b0;
    drive();
    step();  // reset state: all outputs zero

    // 1: store then load a word
    nwr = 0;
    qpush(0, mk(1'b1, 1'b0, 4, 8, 32'hDF0D873C)); drive(); run_idle(20);
    check("t1_store_wr_cycles", nwr, 1);
    check("t1_store_lat", last_resp_cyc - last_ready_cyc, 2);
    check("t1_store_rdata", last_rdata, 0);
    qpush(0, mk(1'b0, 1'b0, 4, 8, 0)); drive(); run_idle(20);
    check("t1_load_rdata", last_rdata, 32'hDF0D873C);
    check("t1_load_err", last_err, 0);

    // 2: sub-word loads
    qpush(0, mk(1'b0, 1'b0, 1, 9, 0));  drive(); run_idle(20);
    check("t2_b9_signed", last_rdata, 32'hFFFFFF87);
    qpush(0, mk(1'b0, 1'b1, 2, 10, 0)); drive(); run_idle(20);
    check("t2_h10_unsigned", last_rdata, 32'h0000DF0D);
    qpush(0, mk(1'b0, 1'b0, 2, 8, 0));  drive(); run_idle(20);
    check("t2_h8_signed", last_rdata, 32'hFFFF873C);
    qpush(1, mk(1'b0, 1'b1, 4, 8, 0));  drive(); run_idle(20);
    check("t2_p1_word", last_rdata, 32'hDF0D873C);

    // 3: both ports busy -> strict alternation, 3-cycle spacing
    gport.delete(); gcyc.delete();
    for (int k = 0; k < 3; k++) begin
      qpush(0, rand_legal_load(1 << $urandom_range(0, 2)));
      qpush(1, rand_legal_load(1 << $urandom_range(0, 2)));
    end
    drive(); run_idle(60);
    check("t3_grants", gport.size(), 6);
    for (int k = 0; k < gport.size() && k < 6; k++) begin
      check("t3_order", gport[k], k % 2);
      if (k > 0) check("t3_spacing", gcyc[k] - gcyc[k-1], 3);
    end

    // 4: illegal commands
    for (int k = 0; k < 4; k++) begin
      nwr = 0; nrd = 0;
      qpush(0, mk(1'(k), 1'b0, e_sz[k], e_ad[k], 32'hA5A5A5A5)); drive(); run_idle(20);
      check("t4_err", last_err, 1);
      check("t4_rdata", last_rdata, 0);
      check("t4_strobes", nwr + nrd, 0);
      check("t4_lat", last_resp_cyc - last_ready_cyc, 1);
    end

    // 5: reset during ACCESS of a port-1 load
    snap_v = nresp1;
    qpush(1, mk(1'b0, 1'b0, 4, 4, 0)); drive();
    step();                       // accept
    reset = 1'b1; drive();
    step();                       // ACCESS cycle, reset sampled at its end
    reset = 1'b0; drive();
    step(); step();
    check("t5_no_resp", nresp1, snap_v);
    check("t5_addr_clr", address, 0);
    gport.delete(); gcyc.delete();
    qpush(1, mk(1'b0, 1'b0, 4, 8, 0)); drive();
    step();
    check("t5_p1_wins", (gport.size() == 1) ? gport[0] : -1, 1);
    run_idle(20);
    check("t5_p1_rdata", last_rdata, 32'hDF0D873C);

    // 6: port 1 withdraws its request while port 0 owns the memory
    snap_r = nready1; snap_v = nresp1;
    qpush(0, mk(1'b1, 1'b0, 2, 20, $urandom)); drive();
    step();
    qpush(1, mk(1'b0, 1'b0, 4, 20, 0)); drive();
    step();
    q1.delete(); drive();
    run_idle(20);
    check("t6_p1_ready", nready1, snap_r);
    check("t6_p1_resp", nresp1, snap_v);
    check("t6_p0_err", last_err, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (qsz(i) == 0 && $urandom_range(0, 2) == 0) qpush(i, rand_cmd());
        else if (qsz(i) > 0 && $urandom_range(0, 19) == 0) qpop(i);
      end
      drive();
      step();
    end
    run_idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
